// File: rtl/ad7621_line_packer.sv
// ad7621_line_packer
//   Clamps offset-corrected ADC pixels to a programmable ceiling and packs
//   pixel pairs into 32-bit words. Words go into a ping-pong pair of line
//   banks. A finished line is handed to the host read side. If the host
//   has not yet drained the previous line, the new line is dropped.
//
// Ports
//   sys_clk           single rising-edge clock
//   sys_rst_n         synchronous active-low reset
//   line_restart      abort the line being written (pairs with ADC restart)
//   FPGA_MAXSATVALUE  unsigned saturation ceiling for incoming pixels
//   pix_di/pix_valid  pixel data and its one-cycle strobe
//   rd_en             host read request, one word per asserted cycle
//   rd_do/rd_valid    packed read word, one cycle after an accepted rd_en
//   line_ready        a complete line is readable
//   line_cnt          delivered lines (wraps)
//   drop_cnt          dropped lines (saturates at 255)
//   overflow          sticky, set on any dropped line
//
// Read FSM
//   state | meaning
//   IDLE  | no readable line; rd_en is ignored
//   READ  | read bank holds a full line; rd_en fetches words in order

module ad7621_line_packer #(
  parameter int PIXELS_PER_LINE = 2048,
  parameter int WORDS_PER_LINE  = PIXELS_PER_LINE / 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        line_restart,
  input  logic [15:0] FPGA_MAXSATVALUE,
  input  logic [15:0] pix_di,
  input  logic        pix_valid,
  input  logic        rd_en,
  output logic [31:0] rd_do,
  output logic        rd_valid,
  output logic        line_ready,
  output logic [15:0] line_cnt,
  output logic [7:0]  drop_cnt,
  output logic        overflow
);

  localparam int IDX_W = (PIXELS_PER_LINE > 2) ? $clog2(PIXELS_PER_LINE) : 1;
  localparam int AW    = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [IDX_W-1:0] LAST_PIX  = IDX_W'(PIXELS_PER_LINE - 1);
  localparam logic [AW-1:0]    LAST_WORD = AW'(WORDS_PER_LINE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  rd_state_t        rd_state;
  logic [IDX_W-1:0] pix_idx;
  logic [15:0]      lo_half;
  logic             wr_bank;
  logic             rd_full;
  logic [AW-1:0]    rd_addr;

  logic [31:0] mem [2][WORDS_PER_LINE];

  logic [15:0]   pix_sat;
  logic          pix_take;
  logic          line_done;
  logic          rd_take;
  logic          rd_release;
  logic          line_accept;
  logic          line_drop;
  logic [AW-1:0] wr_addr;

  assign pix_sat    = (pix_di > FPGA_MAXSATVALUE) ? FPGA_MAXSATVALUE : pix_di;
  // a pixel arriving together with line_restart belongs to the aborted line
  assign pix_take   = pix_valid && !line_restart;
  assign line_done  = pix_take && (pix_idx == LAST_PIX);
  assign rd_take    = (rd_state == READ) && rd_en;
  assign rd_release = rd_take && (rd_addr == LAST_WORD);
  // a release in the same cycle frees the read bank in time for this line
  assign line_accept = line_done && (!rd_full || rd_release);
  assign line_drop   = line_done && !line_accept;
  assign wr_addr     = AW'(pix_idx >> 1);
  assign line_ready  = (rd_state == READ);

  // bank storage is deliberately not reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst_n && pix_take && pix_idx[0]) begin
      mem[wr_bank][wr_addr] <= {pix_sat, lo_half};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rd_state <= IDLE;
      pix_idx  <= '0;
      lo_half  <= '0;
      wr_bank  <= 1'b0;
      rd_full  <= 1'b0;
      rd_addr  <= '0;
      rd_do    <= '0;
      rd_valid <= 1'b0;
      line_cnt <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      rd_valid <= rd_take;
      if (rd_take) begin
        rd_do   <= mem[~wr_bank][rd_addr];
        rd_addr <= rd_release ? '0 : rd_addr + AW'(1);
      end

      if (line_restart) begin
        pix_idx <= '0;
      end else if (pix_valid) begin
        if (!pix_idx[0]) lo_half <= pix_sat;
        pix_idx <= line_done ? '0 : pix_idx + IDX_W'(1);
      end

      // on accept the old write bank becomes the (full) read bank
      if (line_accept) begin
        wr_bank  <= ~wr_bank;
        rd_full  <= 1'b1;
        line_cnt <= line_cnt + 16'd1;
      end else if (rd_release) begin
        rd_full <= 1'b0;
      end

      if (line_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end

      case (rd_state)
        IDLE: if (line_accept || rd_full) rd_state <= READ;
        READ: if (rd_release) rd_state <= IDLE;
        default: rd_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ad7621_line_packer.sv
module tb_ad7621_line_packer;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        line_restart;
  logic [15:0] maxsat;
  logic [15:0] pix_di;
  logic        pix_valid;
  logic        rd_en;
  logic [31:0] rd_do;
  logic        rd_valid;
  logic        line_ready;
  logic [15:0] line_cnt;
  logic [7:0]  drop_cnt;
  logic        overflow;

  always #5 sys_clk = ~sys_clk;

  ad7621_line_packer dut (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .line_restart     (line_restart),
    .FPGA_MAXSATVALUE (maxsat),
    .pix_di           (pix_di),
    .pix_valid        (pix_valid),
    .rd_en            (rd_en),
    .rd_do            (rd_do),
    .rd_valid         (rd_valid),
    .line_ready       (line_ready),
    .line_cnt         (line_cnt),
    .drop_cnt         (drop_cnt),
    .overflow         (overflow)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t exp_q[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  // scoreboard monitor: each expected word must show up exactly on its due cycle
  always @(negedge sys_clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_do !== e.d) begin
        errors++;
        $display("FAIL rd_word got valid=%0b data=%h want valid=1 data=%h",
                 rd_valid, rd_do, e.d);
      end
    end else if (rd_valid === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL rd_valid_unexpected got 1 want 0 (data=%h)", rd_do);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [15:0] pd, input logic re,
                       input logic lr, input logic push, input logic [31:0] ed);
    @(negedge sys_clk);
    pix_valid    = pv;
    pix_di       = pd;
    rd_en        = re;
    line_restart = lr;
    if (push) exp_q.push_back('{ed, cyc + 1});
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic pix(input logic [15:0] d);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] e);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, e);
  endtask

  task automatic do_reset(input int n);
    @(negedge sys_clk);
    sys_rst_n    = 1'b0;
    pix_valid    = 1'b0;
    rd_en        = 1'b0;
    line_restart = 1'b0;
    repeat (n) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    sys_rst_n    = 1'b0;
    line_restart = 1'b0;
    pix_valid    = 1'b0;
    rd_en        = 1'b0;
    pix_di       = 16'h0;
    maxsat       = 16'hFFFF;

    // reset state
    do_reset(2);
    chk("rst_line_ready", 32'(line_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_do", rd_do, 32'h0);
    chk("rst_line_cnt", 32'(line_cnt), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // ramp line, full readback; rd_en in IDLE must be ignored
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2048; i++) pix(16'(i));
    idle();
    chk("s1_line_ready", 32'(line_ready), 32'd1);
    chk("s1_line_cnt", 32'(line_cnt), 32'd1);
    chk("s1_drop_cnt", 32'(drop_cnt), 32'd0);
    for (int k = 0; k < 1024; k++) begin
      rd({16'(2 * k + 1), 16'(2 * k)});
      if (k == 1023) chk("s1_ready_before_last", 32'(line_ready), 32'd1);
    end
    idle();
    chk("s1_ready_drop", 32'(line_ready), 32'd0);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    idle();
    chk("s1_line_cnt_after", 32'(line_cnt), 32'd1);

    // saturation at a 1000 ceiling
    do_reset(1);
    maxsat = 16'd1000;
    pix(16'd999);
    pix(16'd1000);
    pix(16'd1001);
    pix(16'hFFFF);
    for (int i = 4; i < 2048; i++) pix((i % 2 == 0) ? 16'd500 : 16'd2000);
    idle();
    chk("s2_line_ready", 32'(line_ready), 32'd1);
    rd(32'h03E8_03E7);
    rd(32'h03E8_03E8);
    for (int k = 2; k < 1024; k++) rd(32'h03E8_01F4);
    idle();
    chk("s2_ready_drop", 32'(line_ready), 32'd0);
    maxsat = 16'hFFFF;

    // three lines without reads: two drops, first line intact
    do_reset(1);
    for (int i = 0; i < 2048; i++) pix(16'(i));
    for (int i = 0; i < 2048; i++) pix(16'hAAAA);
    for (int i = 0; i < 2048; i++) pix(16'h5555);
    idle();
    chk("s3_line_cnt", 32'(line_cnt), 32'd1);
    chk("s3_drop_cnt", 32'(drop_cnt), 32'd2);
    chk("s3_overflow", 32'(overflow), 32'd1);
    chk("s3_line_ready", 32'(line_ready), 32'd1);
    for (int k = 0; k < 1024; k++) rd({16'(2 * k + 1), 16'(2 * k)});
    idle();
    chk("s3_ready_drop", 32'(line_ready), 32'd0);
    chk("s3_overflow_sticky", 32'(overflow), 32'd1);

    // restart after pixel 5, coincident pixel discarded
    do_reset(1);
    for (int i = 0; i < 6; i++) pix(16'(16'h7000 + i));
    drive(1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 2048; i++) pix(16'(256 + i));
    idle();
    chk("s4_line_cnt", 32'(line_cnt), 32'd1);
    chk("s4_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("s4_line_ready", 32'(line_ready), 32'd1);
    rd({16'(257), 16'(256)});
    drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    idle();
    chk("s4_ready_after_restart", 32'(line_ready), 32'd1);
    for (int k = 1; k < 1024; k++) rd({16'(256 + 2 * k + 1), 16'(256 + 2 * k)});
    idle();
    chk("s4_ready_drop", 32'(line_ready), 32'd0);

    // last read coincides with line-complete: no drop, one-cycle gap
    do_reset(1);
    for (int i = 0; i < 2048; i++) pix(16'(i));
    for (int j = 0; j < 2048; j++) begin
      drive(1'b1, 16'(16'h0800 + j), j >= 1024, 1'b0, j >= 1024,
            {16'(2 * (j - 1024) + 1), 16'(2 * (j - 1024))});
    end
    idle();
    chk("s5_ready_gap", 32'(line_ready), 32'd0);
    chk("s5_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("s5_overflow", 32'(overflow), 32'd0);
    chk("s5_line_cnt", 32'(line_cnt), 32'd2);
    idle();
    chk("s5_ready_reassert", 32'(line_ready), 32'd1);
    for (int k = 0; k < 1024; k++) rd({16'(16'h0800 + 2 * k + 1), 16'(16'h0800 + 2 * k)});
    idle();
    chk("s5_ready_drop", 32'(line_ready), 32'd0);

    // reset mid-read at word 500 with a partial line in flight
    do_reset(1);
    for (int i = 0; i < 2048; i++) pix(16'(i));
    for (int i = 0; i < 2048; i++) pix(16'h1234);
    idle();
    chk("s6_drop_cnt_pre", 32'(drop_cnt), 32'd1);
    chk("s6_overflow_pre", 32'(overflow), 32'd1);
    for (int k = 0; k < 500; k++) rd({16'(2 * k + 1), 16'(2 * k)});
    for (int i = 0; i < 3; i++) pix(16'h4444);
    do_reset(1);
    chk("s6_rst_line_ready", 32'(line_ready), 32'd0);
    chk("s6_rst_line_cnt", 32'(line_cnt), 32'd0);
    chk("s6_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("s6_rst_overflow", 32'(overflow), 32'd0);
    chk("s6_rst_rd_valid", 32'(rd_valid), 32'd0);
    for (int i = 0; i < 2048; i++) pix(16'(16'h0300 + i));
    idle();
    chk("s6_line_cnt", 32'(line_cnt), 32'd1);
    chk("s6_line_ready", 32'(line_ready), 32'd1);
    for (int k = 0; k < 1024; k++) rd({16'(16'h0300 + 2 * k + 1), 16'(16'h0300 + 2 * k)});
    idle();
    chk("s6_ready_drop", 32'(line_ready), 32'd0);

    idle();
    idle();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad7621_line_packer.md
AD7621_LINE_PACKER -- requirements
Module: ad7621_line_packer

Interface
REQ-001 Parameter PIXELS_PER_LINE, default 2048, SHALL set the pixels per line; it is even, 2..2048.
REQ-002 Parameter WORDS_PER_LINE, default PIXELS_PER_LINE/2, SHALL set the packed 32-bit words per line.
REQ-003 sys_clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-004 sys_rst_n  in  1  reset; SHALL be synchronous and active-low.
REQ-005 line_restart  in  1  SHALL abort the partially written line; driven alongside the ADC restart.
REQ-006 FPGA_MAXSATVALUE  in  16  SHALL be the unsigned saturation ceiling.
REQ-007 pix_di  in  16  SHALL be the offset-corrected pixel from the ADC capture stage.
REQ-008 pix_valid  in  1  SHALL be a one-cycle strobe qualifying pix_di.
REQ-009 rd_en  in  1  SHALL be the host read request, one word per asserted cycle.
REQ-010 rd_do  out  32  SHALL carry the packed read word.
REQ-011 rd_valid  out  1  SHALL qualify rd_do.
REQ-012 line_ready  out  1  SHALL mean a complete line is readable.
REQ-013 line_cnt  out  16  SHALL count delivered lines, wrapping.
REQ-014 drop_cnt  out  8  SHALL count dropped lines, saturating at 255.
REQ-015 overflow  out  1  SHALL be a sticky flag set on any dropped line.

Function
REQ-016 Each pix_valid sample SHALL be clamped: out = (pix_di > FPGA_MAXSATVALUE) ? FPGA_MAXSATVALUE : pix_di, unsigned.
REQ-017 Even pixel index SHALL go to bits [15:0] and odd to [31:16]; the word SHALL be written on the odd pixel at word address pix_idx>>1 of the write bank.
REQ-018 Storage SHALL be two banks (ping-pong) of WORDS_PER_LINE x 32; wr_bank SHALL select the write bank and the other bank SHALL be the read bank.
REQ-019 pix_idx SHALL increment per pix_valid; on the pixel at index PIXELS_PER_LINE-1 it SHALL return to 0 and a line-complete event SHALL occur.
REQ-020 At line-complete with the read bank free, the write bank SHALL become full, wr_bank SHALL toggle, line_cnt SHALL increment and line_ready SHALL assert on the next cycle.
REQ-021 At line-complete with the read bank still full, the line SHALL be dropped: no toggle, drop_cnt SHALL increment and saturate, and overflow SHALL set; the next line SHALL overwrite the same bank.
REQ-022 The read FSM SHALL have states IDLE (line_ready=0) and READ (line_ready=1); IDLE->READ on a full bank, READ->IDLE when the last word is accepted.
REQ-023 In READ, rd_en SHALL fetch word rd_addr; rd_do/rd_valid SHALL appear exactly one cycle later and rd_addr SHALL increment.
REQ-024 rd_en in IDLE SHALL be ignored, leaving rd_valid 0 and rd_addr unchanged.
REQ-025 On acceptance of word WORDS_PER_LINE-1, rd_addr SHALL return to 0, the bank SHALL be freed and line_ready SHALL deassert on the next cycle, the same cycle the last rd_valid is high.
REQ-026 If a bank release and a line-complete occur in the same cycle, the release SHALL take priority and the line SHALL be accepted with no drop.
REQ-027 line_restart SHALL clear pix_idx and discard any half-packed word; it SHALL not affect the read bank, line_ready, rd_addr or any counter.
REQ-028 pix_valid coincident with line_restart SHALL be discarded.
REQ-029 rd_valid SHALL be 1 only in the cycle after an accepted rd_en; rd_do SHALL be don't-care when rd_valid=0.

Reset
REQ-030 While sys_rst_n=0 at a clock edge: pix_idx=0, wr_bank=0, both banks free, rd_addr=0, FSM=IDLE, line_ready=0, rd_valid=0, rd_do=0, line_cnt=0, drop_cnt=0, overflow=0; bank contents are not cleared.
REQ-031 Reset mid-line or mid-read SHALL abandon all in-flight data; the first pix_valid after release SHALL be pixel 0.

Verification
REQ-032 Scenario: MAXSAT=0xFFFF, 2048 pixels valued 0..2047, then 1024 rd_en -> words {2k+1,2k} for k=0..1023, line_cnt=1, line_ready drops after the last word.
REQ-033 Scenario: MAXSAT=1000, pixels 999/1000/1001/0xFFFF -> packed values 999,1000,1000,1000.
REQ-034 Scenario: three lines with no reads -> line_cnt=1, drop_cnt=2, overflow=1; the first line's data is intact on readback.
REQ-035 Scenario: line_restart after pixel 5 (odd), then 2048 pixels -> the delivered line holds only post-restart data; the word at address 0 is from the new line.
REQ-036 Scenario: final rd_en accepted in the same cycle as the line-complete pixel -> no drop, drop_cnt=0, line_ready reasserts one cycle after the deassert.
REQ-037 Scenario: sys_rst_n low for 1 cycle mid-read at word 500 -> line_ready=0, counters 0, the next line reads from address 0.
